iterative_divider: RTL and testbench

//   RV32M divide/remainder unit (DIV, DIVU, REM, REMU) on the register-file datapath.

---
 rtl/iterative_divider.sv | 116 +++++++++++
 tb/tb_iterative_divider.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/iterative_divider.sv
// RV32M divide/remainder unit: restoring division, one quotient bit per clock.
// Divide-by-zero and signed overflow are resolved at accept and skip the iteration.
module iterative_divider #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [1:0]      funct,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   input  logic [4:0]      rd_in,
   input  logic            flush,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic [4:0]      rd_out
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;
   localparam int CW = $clog2(XLEN);

   logic [1:0]      state;
   logic [XLEN-1:0] rem, dvd, dvs, quo;
   logic [CW-1:0]   cnt;
   logic            neg_q, neg_r, sel_r;
   logic [4:0]      rd_q;

   logic            signed_op, a_neg, b_neg, div_zero, ovf;
   logic [XLEN-1:0] a_abs, b_abs, spec_res, q_fix, r_fix, rem_sub;
   logic [XLEN:0]   shifted;
   logic            ge;

   always_comb begin
      signed_op = ~funct[0];
      a_neg     = signed_op & op_a[XLEN-1];
      b_neg     = signed_op & op_b[XLEN-1];
      a_abs     = a_neg ? -op_a : op_a;
      b_abs     = b_neg ? -op_b : op_b;
      div_zero  = (op_b == '0);
      ovf       = signed_op & (op_a == {1'b1, {(XLEN-1){1'b0}}}) & (op_b == '1);
      // overflow quotient equals the dividend itself (most negative value)
      if (div_zero) spec_res = funct[1] ? op_a : '1;
      else          spec_res = funct[1] ? '0 : op_a;
      // partial remainder needs one extra bit before the trial subtract
      shifted   = {rem, dvd[XLEN-1]};
      ge        = (shifted >= {1'b0, dvs});
      rem_sub   = shifted[XLEN-1:0] - dvs;
      q_fix     = neg_q ? -quo : quo;
      r_fix     = neg_r ? -rem : rem;
   end

   assign busy = (state == S_CALC) || (state == S_FIX);
   assign done = (state == S_DONE) && !flush;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= S_IDLE;
         rem    <= '0;
         dvd    <= '0;
         dvs    <= '0;
         quo    <= '0;
         cnt    <= '0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         sel_r  <= 1'b0;
         rd_q   <= '0;
         result <= '0;
         rd_out <= '0;
      end else if (flush) begin
         state <= S_IDLE;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  rd_q  <= rd_in;
                  sel_r <= funct[1];
                  neg_q <= a_neg ^ b_neg;
                  neg_r <= a_neg;
                  dvd   <= a_abs;
                  dvs   <= b_abs;
                  rem   <= '0;
                  quo   <= '0;
                  cnt   <= CW'(XLEN-1);
                  if (div_zero || ovf) begin
                     result <= spec_res;
                     rd_out <= rd_in;
                     state  <= S_DONE;
                  end else begin
                     state <= S_CALC;
                  end
               end else begin
                  state <= S_IDLE;
               end
            end
            S_CALC: begin
               dvd <= {dvd[XLEN-2:0], 1'b0};
               rem <= ge ? rem_sub : shifted[XLEN-1:0];
               quo <= {quo[XLEN-2:0], ge};
               cnt <= cnt - CW'(1);
               if (cnt == '0) state <= S_FIX;
            end
            S_FIX: begin
               result <= sel_r ? r_fix : q_fix;
               rd_out <= rd_q;
               state  <= S_DONE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_iterative_divider.sv
// Bench for iterative_divider: arithmetic reference model checked every cycle,
// plus directed vectors with literal expected results and latencies.
module tb_iterative_divider;
   localparam int XLEN = 32;

   logic        clk = 1'b0, reset = 1'b0, start = 1'b0, flush = 1'b0;
   logic [1:0]  funct = 2'b00;
   logic [31:0] op_a = '0, op_b = '0;
   logic [4:0]  rd_in = '0;
   logic        busy, done;
   logic [31:0] result;
   logic [4:0]  rd_out;

   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   iterative_divider #(.XLEN(XLEN)) dut (
      .clk(clk), .reset(reset), .start(start), .funct(funct), .op_a(op_a), .op_b(op_b),
      .rd_in(rd_in), .flush(flush), .busy(busy), .done(done), .result(result), .rd_out(rd_out)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
      int signed sa, sb;
      sa = a;
      sb = b;
      if (b == 0) return f[1] ? a : 32'hFFFF_FFFF;
      if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f[1] ? 32'h0 : 32'h8000_0000;
      case (f)
         2'b00:   return sa / sb;
         2'b01:   return a / b;
         2'b10:   return sa % sb;
         default: return a % b;
      endcase
   endfunction

   function automatic bit is_special(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
      return (b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
   endfunction

   // Model: one pending op with a countdown to its done cycle.
   bit          m_pend;
   int          m_left;
   logic [31:0] m_res, m_out;
   logic [4:0]  m_rd, m_out_rd;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_pend <= 0; m_left <= 0; m_res <= '0; m_rd <= '0; m_out <= '0; m_out_rd <= '0;
      end else if (flush) begin
         m_pend <= 0;
      end else if (start && !(m_pend && m_left > 1)) begin
         m_pend <= 1;
         m_left <= is_special(funct, op_a, op_b) ? 1 : XLEN + 2;
         m_res  <= ref_op(funct, op_a, op_b);
         m_rd   <= rd_in;
         if (is_special(funct, op_a, op_b)) begin
            m_out    <= ref_op(funct, op_a, op_b);
            m_out_rd <= rd_in;
         end
      end else if (m_pend) begin
         if (m_left == 2) begin
            m_out    <= m_res;
            m_out_rd <= m_rd;
         end
         if (m_left == 1) m_pend <= 0;
         m_left <= m_left - 1;
      end
   end

   always @(negedge clk) begin
      check("cyc_done",   {31'b0, done},  {31'b0, m_pend && m_left == 1 && !flush});
      check("cyc_busy",   {31'b0, busy},  {31'b0, m_pend && m_left > 1});
      check("cyc_result", result, m_out);
      check("cyc_rd_out", {27'b0, rd_out}, {27'b0, m_out_rd});
   end

   task automatic issue(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
      @(posedge clk); #2;
      funct = f; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
   endtask

   task automatic wait_done(output int lat, output int bcnt);
      lat = 0; bcnt = 0;
      for (int n = 1; n <= 60; n++) begin
         @(negedge clk);
         if (busy) bcnt++;
         if (done) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic do_op(input string name, input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp, input int exp_lat, input int exp_busy);
      int lat, bc;
      issue(f, a, b, rd);
      wait_done(lat, bc);
      check({name, "_lat"},  lat, exp_lat);
      check({name, "_busy"}, bc, exp_busy);
      check({name, "_res"},  result, exp);
      check({name, "_rd"},   {27'b0, rd_out}, {27'b0, rd});
   endtask

   initial begin
      int lat, bc, ndone;
      #3;
      check("rst_busy",   {31'b0, busy}, 0);
      check("rst_done",   {31'b0, done}, 0);
      check("rst_result", result, 0);
      check("rst_rd_out", {27'b0, rd_out}, 0);
      #9 reset = 1'b1;

      do_op("divu_100_7",  2'b01, 32'd100,       32'd7,          5'd5,  32'd14,        34, 33);
      do_op("div_m7_2",    2'b00, 32'hFFFF_FFF9, 32'd2,          5'd1,  32'hFFFF_FFFD, 34, 33);
      do_op("rem_m7_2",    2'b10, 32'hFFFF_FFF9, 32'd2,          5'd2,  32'hFFFF_FFFF, 34, 33);
      do_op("remu_m7_2",   2'b11, 32'hFFFF_FFF9, 32'd2,          5'd3,  32'd1,         34, 33);
      do_op("div_7_m2",    2'b00, 32'd7,         32'hFFFF_FFFE,  5'd4,  32'hFFFF_FFFD, 34, 33);
      do_op("rem_7_m2",    2'b10, 32'd7,         32'hFFFF_FFFE,  5'd6,  32'd1,         34, 33);
      do_op("div_5_0",     2'b00, 32'd5,         32'd0,          5'd7,  32'hFFFF_FFFF, 1,  0);
      do_op("remu_5_0",    2'b11, 32'd5,         32'd0,          5'd8,  32'd5,         1,  0);
      do_op("div_ovf",     2'b00, 32'h8000_0000, 32'hFFFF_FFFF,  5'd9,  32'h8000_0000, 1,  0);
      do_op("rem_ovf",     2'b10, 32'h8000_0000, 32'hFFFF_FFFF,  5'd10, 32'd0,         1,  0);
      do_op("divu_max",    2'b01, 32'hFFFF_FFFF, 32'd1,          5'd0,  32'hFFFF_FFFF, 34, 33);

      // back-to-back: second start held during the DONE cycle
      issue(2'b01, 32'd100, 32'd7, 5'd5);
      repeat (33) @(posedge clk);
      #2;
      funct = 2'b11; op_a = 32'd100; op_b = 32'd7; rd_in = 5'd6; start = 1'b1;
      @(negedge clk);
      check("b2b_first_done", {31'b0, done}, 1);
      check("b2b_first_res",  result, 32'd14);
      @(posedge clk); #2;
      start = 1'b0;
      wait_done(lat, bc);
      check("b2b_second_lat", lat, 34);
      check("b2b_second_res", result, 32'd2);
      check("b2b_second_rd",  {27'b0, rd_out}, 32'd6);

      // ignored second start, then flush aborts the op
      issue(2'b01, 32'd1000, 32'd3, 5'd11);
      repeat (4) @(posedge clk);
      #2;
      funct = 2'b01; op_a = 32'd9; op_b = 32'd2; rd_in = 5'd12; start = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #2 flush = 1'b1;
      @(posedge clk); #2;
      flush = 1'b0;
      @(negedge clk);
      check("flush_busy", {31'b0, busy}, 0);
      ndone = 0;
      repeat (45) begin
         @(negedge clk);
         if (done) ndone++;
      end
      check("flush_nodone", ndone, 0);
      check("flush_keep_res", result, 32'd2);
      check("flush_keep_rd",  {27'b0, rd_out}, 32'd6);

      // asynchronous reset in the middle of an op
      issue(2'b01, 32'd50, 32'd5, 5'd13);
      repeat (3) @(posedge clk);
      #3 reset = 1'b0;
      #1;
      check("arst_busy",   {31'b0, busy}, 0);
      check("arst_done",   {31'b0, done}, 0);
      check("arst_result", result, 0);
      check("arst_rd_out", {27'b0, rd_out}, 0);
      #4 reset = 1'b1;
      ndone = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) ndone++;
      end
      check("arst_nodone", ndone, 0);

      do_op("post_rst_div", 2'b00, 32'd100, 32'hFFFF_FFF9, 5'd14, 32'hFFFF_FFF2, 34, 33);

      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
